// File: rtl/round_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : round_sequencer_pkg
//  Description : Shared definitions for the tug-of-war round sequencer:
//                FSM state encoding, scorer win patterns, and LFSR
//                seed/taps with a single-step helper function.
//  Revision    : 1.0 - initial release
// ============================================================================
package round_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_ARM      = 3'd0,
      ST_WAIT     = 3'd1,
      ST_LIGHT    = 3'd2,
      ST_RESULT   = 3'd3,
      ST_GAMEOVER = 3'd4
   } state_t;

   // Scorer display patterns {L3..R3} that mark a finished game
   localparam logic [6:0] c_score_wl = 7'b1110000;
   localparam logic [6:0] c_score_wr = 7'b0000111;

   // x^8 + x^6 + x^5 + x^4 + 1 : feedback from bits 7,5,4,3
   localparam logic [7:0] c_lfsr_seed = 8'h01;
   localparam logic [7:0] c_lfsr_taps = 8'b1011_1000;

   function automatic logic [7:0] lfsr_next(input logic [7:0] v);
      return {v[6:0], ^(v & c_lfsr_taps)};
   endfunction

   function automatic logic is_win_pattern(input logic [6:0] s);
      return (s == c_score_wl) || (s == c_score_wr);
   endfunction

endpackage
`default_nettype wire

// File: rtl/round_sequencer_push_sync.sv
`default_nettype none
// ============================================================================
//  Module      : round_sequencer_push_sync
//  Description : Synchronises one raw push button and produces a registered
//                one-cycle pulse on its rising edge.
//  Ports       : clk, rst_n   - clock, async active-low reset
//                i_pb         - raw asynchronous button (active high)
//                o_level      - synchronised button level
//                o_push       - one-cycle pulse, SYNC_STAGES cycles after
//                               the edge that first samples i_pb high
//  Revision    : 1.0 - initial release
// ============================================================================
module round_sequencer_push_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_pb,
   output logic o_level,
   output logic o_push
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic                   r_push;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= '0;
         r_prev <= 1'b0;
         r_push <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_pb};
         r_prev <= r_sync[SYNC_STAGES-1];
         // Registered edge so the pulse lands exactly SYNC_STAGES edges
         // after the sampling edge; a held button never re-fires.
         r_push <= r_sync[SYNC_STAGES-1] & ~r_prev;
      end
   end

   assign o_level = r_sync[SYNC_STAGES-1];
   assign o_push  = r_push;

endmodule
`default_nettype wire

// File: rtl/round_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : round_sequencer
//  Description : Sequences each tug-of-war round: arm, pseudo-random
//                lights-off delay, lights on, first-push arbitration, then a
//                hold period for display. Stops once the scorer shows a win.
//  Ports       : clk, rst_n    - clock, async active-low reset
//                i_pb_l/i_pb_r - raw push buttons (async, active high)
//                i_score[6:0]  - scorer display {L3..R3}
//                o_leds_on     - lights on (registered)
//                o_winrnd      - one-cycle pulse, push accepted (registered)
//                o_right       - with o_winrnd: 1 = right was first
//                o_game_over   - high while the game is over (registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module round_sequencer
   import round_sequencer_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 16,
   parameter int DELAY_MIN   = 1000,
   parameter int DELAY_SHIFT = 4,
   parameter int HOLD_CYCLES = 5000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_pb_l,
   input  logic       i_pb_r,
   input  logic [6:0] i_score,
   output logic       o_leds_on,
   output logic       o_winrnd,
   output logic       o_right,
   output logic       o_game_over
);

   // ------------------------------------------------------------------
   // Elaboration-time parameter sanity
   // ------------------------------------------------------------------
   localparam longint c_max_delay = longint'(DELAY_MIN) + (longint'(255) << DELAY_SHIFT);
   localparam longint c_cnt_max   = (longint'(1) << CNT_W) - 1;

   if (SYNC_STAGES < 2) begin : g_chk_sync
      $error("round_sequencer: SYNC_STAGES must be >= 2");
   end
   if (c_max_delay > c_cnt_max) begin : g_chk_delay
      $error("round_sequencer: DELAY_MIN + (255 << DELAY_SHIFT) overflows CNT_W");
   end
   if (longint'(HOLD_CYCLES) > c_cnt_max) begin : g_chk_hold
      $error("round_sequencer: HOLD_CYCLES overflows CNT_W");
   end

   // ------------------------------------------------------------------
   // Button synchronisers
   // ------------------------------------------------------------------
   logic w_lvl_l, w_lvl_r, w_push_l, w_push_r;

   round_sequencer_push_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_l (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_pb    (i_pb_l),
      .o_level (w_lvl_l),
      .o_push  (w_push_l)
   );

   round_sequencer_push_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_r (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_pb    (i_pb_r),
      .o_level (w_lvl_r),
      .o_push  (w_push_r)
   );

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [7:0]       r_lfsr;
   logic             r_tie, w_tie_nxt;
   logic             r_leds_on, w_leds_nxt;
   logic             r_winrnd, w_winrnd_nxt;
   logic             r_right, w_right_nxt;
   logic             r_game_over, w_game_nxt;

   logic             w_any_push;
   logic             w_both_push;
   logic [CNT_W-1:0] w_delay_load;
   logic [CNT_W-1:0] w_hold_load;

   assign w_any_push   = w_push_l | w_push_r;
   assign w_both_push  = w_push_l & w_push_r;
   assign w_delay_load = CNT_W'(DELAY_MIN) + (CNT_W'(r_lfsr) << DELAY_SHIFT);
   assign w_hold_load  = CNT_W'(HOLD_CYCLES);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_ARM;
         r_cnt       <= '0;
         r_lfsr      <= c_lfsr_seed;
         r_tie       <= 1'b0;
         r_leds_on   <= 1'b0;
         r_winrnd    <= 1'b0;
         r_right     <= 1'b0;
         r_game_over <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_lfsr      <= lfsr_next(r_lfsr);
         r_tie       <= w_tie_nxt;
         r_leds_on   <= w_leds_nxt;
         r_winrnd    <= w_winrnd_nxt;
         r_right     <= w_right_nxt;
         r_game_over <= w_game_nxt;
      end
   end

   // Next-state and next-output logic. Outputs are computed for the state
   // being entered so the registered outputs line up with r_state.
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_tie_nxt    = r_tie;
      w_leds_nxt   = r_leds_on;
      w_winrnd_nxt = 1'b0;
      w_right_nxt  = r_right;
      w_game_nxt   = 1'b0;

      case (r_state)
         ST_ARM: begin
            w_leds_nxt = 1'b0;
            // A button still held from the last round keeps us here
            if (!w_lvl_l && !w_lvl_r) begin
               w_state_nxt = ST_WAIT;
               w_cnt_nxt   = w_delay_load;
            end
         end

         ST_WAIT: begin
            w_leds_nxt = 1'b0;
            // Jump-the-light: a push beats an expiring counter
            if (w_any_push) begin
               w_winrnd_nxt = 1'b1;
               w_right_nxt  = w_both_push ? r_tie : w_push_r;
               w_state_nxt  = ST_RESULT;
               w_cnt_nxt    = w_hold_load;
            end else if (r_cnt == '0) begin
               w_state_nxt = ST_LIGHT;
               w_leds_nxt  = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end

         ST_LIGHT: begin
            w_leds_nxt = 1'b1;
            if (w_any_push) begin
               w_winrnd_nxt = 1'b1;
               w_right_nxt  = w_both_push ? r_tie : w_push_r;
               // Alternate tie winner so neither side is favoured
               if (w_both_push) begin
                  w_tie_nxt = ~r_tie;
               end
               w_state_nxt = ST_RESULT;
               w_cnt_nxt   = w_hold_load;
            end
         end

         ST_RESULT: begin
            // leds_on holds the winrnd-cycle value via the default
            if (r_cnt == '0) begin
               w_leds_nxt = 1'b0;
               if (is_win_pattern(i_score)) begin
                  w_state_nxt = ST_GAMEOVER;
                  w_game_nxt  = 1'b1;
               end else begin
                  w_state_nxt = ST_ARM;
               end
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end

         ST_GAMEOVER: begin
            w_leds_nxt = 1'b0;
            w_game_nxt = 1'b1;
         end

         default: begin
            w_state_nxt = ST_ARM;
            w_leds_nxt  = 1'b0;
         end
      endcase
   end

   assign o_leds_on   = r_leds_on;
   assign o_winrnd    = r_winrnd;
   assign o_right     = r_right;
   assign o_game_over = r_game_over;

endmodule
`default_nettype wire

// File: tb/tb_round_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_round_sequencer
//  Description : Directed self-checking bench for round_sequencer with
//                short delays (DELAY_MIN=4, DELAY_SHIFT=0, HOLD_CYCLES=3).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_round_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       pb_l = 1'b0;
   logic       pb_r = 1'b0;
   logic [6:0] score = 7'd0;
   logic       leds_on, winrnd, right, game_over;

   int n_vec = 0;
   int n_err = 0;

   round_sequencer #(
      .SYNC_STAGES (2),
      .CNT_W       (16),
      .DELAY_MIN   (4),
      .DELAY_SHIFT (0),
      .HOLD_CYCLES (3)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_pb_l      (pb_l),
      .i_pb_r      (pb_r),
      .i_score     (score),
      .o_leds_on   (leds_on),
      .o_winrnd    (winrnd),
      .o_right     (right),
      .o_game_over (game_over)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Release reset; first round loads 4 + lfsr(8'h01) = 5, so WAIT spans
   // edges 2..7 and lights come on after edge 7.
   task automatic release_and_check_light();
      rst_n = 1'b1;
      repeat (6) tick();
      chk("light_early", leds_on, 1'b0);
      tick();
      chk("light_on", leds_on, 1'b1);
      chk("light_no_win", winrnd, 1'b0);
   endtask

   task automatic wait_leds(input string tag);
      int n = 0;
      while (leds_on !== 1'b1 && n < 400) begin
         tick();
         n++;
      end
      chk(tag, leds_on, 1'b1);
   endtask

   // Present buttons for one sampling edge; winrnd must appear exactly
   // three edges after that edge.
   task automatic push(input logic l, input logic r, input logic keep,
                       input logic exp_right, input logic exp_leds);
      pb_l = l;
      pb_r = r;
      tick();
      if (!keep) begin
         pb_l = 1'b0;
         pb_r = 1'b0;
      end
      tick();
      chk("winrnd_t1", winrnd, 1'b0);
      tick();
      chk("winrnd_t2", winrnd, 1'b0);
      tick();
      chk("winrnd_t3", winrnd, 1'b1);
      chk("right", right, exp_right);
      chk("leds_at_win", leds_on, exp_leds);
   endtask

   // Three more RESULT cycles hold leds_on, then leaving RESULT clears it
   task automatic finish_round(input logic exp_leds);
      logic bad = 1'b0;
      repeat (3) begin
         tick();
         if (leds_on !== exp_leds || winrnd !== 1'b0) bad = 1'b1;
      end
      chk("result_hold", bad, 1'b0);
      tick();
      chk("result_exit_leds", leds_on, 1'b0);
      chk("result_exit_win", winrnd, 1'b0);
   endtask

   initial begin
      logic bad;

      // ---- 1: reset state and first lights-on timing
      repeat (3) tick();
      chk("rst_leds", leds_on, 1'b0);
      chk("rst_winrnd", winrnd, 1'b0);
      chk("rst_right", right, 1'b0);
      chk("rst_game_over", game_over, 1'b0);
      release_and_check_light();

      // ---- 2: right push in LIGHT
      push(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      finish_round(1'b1);

      // ---- 3: left jumps the light in WAIT; lights stay off all round
      push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      finish_round(1'b0);

      // ---- 4: simultaneous pushes in LIGHT alternate the winner
      wait_leds("tie1_light");
      push(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      finish_round(1'b1);
      wait_leds("tie2_light");
      push(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      finish_round(1'b1);

      // ---- 5: left held through RESULT blocks ARM
      wait_leds("hold_light");
      push(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      finish_round(1'b1);
      bad = 1'b0;
      repeat (300) begin
         tick();
         if (leds_on !== 1'b0 || winrnd !== 1'b0) bad = 1'b1;
      end
      chk("held_blocks_arm", bad, 1'b0);
      pb_l = 1'b0;
      wait_leds("release_rearms");

      // ---- 6: win pattern ends the game; pushes ignored; reset recovers
      score = 7'b0000111;
      push(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      finish_round(1'b1);
      chk("game_over_set", game_over, 1'b1);
      pb_l = 1'b1;
      pb_r = 1'b1;
      tick();
      pb_l = 1'b0;
      pb_r = 1'b0;
      bad = 1'b0;
      repeat (8) begin
         tick();
         if (winrnd !== 1'b0 || leds_on !== 1'b0 || game_over !== 1'b1) bad = 1'b1;
      end
      chk("game_over_ignores", bad, 1'b0);

      score = 7'd0;
      rst_n = 1'b0;
      #1;
      chk("async_rst_game_over", game_over, 1'b0);
      tick();
      rst_n = 1'b1;
      repeat (3) tick();
      rst_n = 1'b0;
      #1;
      chk("wait_rst_leds", leds_on, 1'b0);
      chk("wait_rst_winrnd", winrnd, 1'b0);
      chk("wait_rst_right", right, 1'b0);
      chk("wait_rst_game", game_over, 1'b0);
      tick();
      // Same lights-on timing as after power-up shows the LFSR restarted
      release_and_check_light();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1);
   end

endmodule
`default_nettype wire
